switch_debouncer: RTL and testbench

Input-conditioning stage that sits directly upstream of the basic_gates logic. It takes raw, asynchronous, bouncing slide-switch or push-button levels and delivers clean, synchronised, debounced levels. Those levels drive the gate inputs a and b. Each channel is independent, and the block is parameterised for any channel count.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_ch.sv | 114 +++++++++++
 rtl/switch_debouncer.sv | 48 ++++
 tb/tb_switch_debouncer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer.
//   db_state_e           : per-channel FSM state encoding (ST_STABLE / ST_COUNTING)
//   DB_CYCLES_DEFAULT    : default qualification window (10 ms at 100 MHz)
//   DB_CYCLES_SIM        : short qualification window used in simulation
package debounce_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

    localparam int unsigned DB_CYCLES_DEFAULT = 1000000;
    localparam int unsigned DB_CYCLES_SIM     = 8;

endpackage

// File: rtl/debounce_ch.sv
// One debounced switch channel: synchroniser chain, two-state qualification
// FSM with its counter, and (with DEBOUNCE_EDGE_EN defined) edge pulses.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   sw_raw     : raw asynchronous switch level
//   sw_db      : debounced level
//   busy       : high while a change is being qualified (COUNTING)
//   sw_rise    : one-cycle pulse on sw_db 0->1 (DEBOUNCE_EDGE_EN only)
//   sw_fall    : one-cycle pulse on sw_db 1->0 (DEBOUNCE_EDGE_EN only)
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_db,
    output logic busy
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic sw_rise,
    output logic sw_fall
`endif
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;

    // NOTE: the synchroniser flops are reset too, so a level sampled before
    // reset can never leak into the qualification after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples the previous stage's
            // old value, giving a true shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        case (state_q)
            ST_STABLE: begin
                if (sync != db_q) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_COUNTING: begin
                if (sync == db_q) begin
                    // Bounce back: the whole window is discarded.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    db_d    = sync;
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign sw_db = db_q;
    assign busy  = (state_q == ST_COUNTING);

`ifdef DEBOUNCE_EDGE_EN
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= db_q;
        end
    end

    // Pulses line up with the first cycle of the new sw_db value.
    assign sw_rise = db_q & ~prev_q;
    assign sw_fall = ~db_q & prev_q;
`else
    // Edge detection not built: no previous-value register, no pulse ports.
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer feeding the basic_gates inputs
// (bit 0 -> a, bit 1 -> b). Each channel is an independent debounce_ch.
// Optional feature macro: DEBOUNCE_EDGE_EN adds sw_rise / sw_fall.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   sw_raw     : [NUM_CH] raw asynchronous switch levels
//   sw_db      : [NUM_CH] debounced levels
//   busy       : [NUM_CH] channel is qualifying a change
//   sw_rise    : [NUM_CH] sw_db 0->1 pulse (DEBOUNCE_EDGE_EN only)
//   sw_fall    : [NUM_CH] sw_db 1->0 pulse (DEBOUNCE_EDGE_EN only)
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sw_raw,
    output logic [NUM_CH-1:0] sw_db,
    output logic [NUM_CH-1:0] busy
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [NUM_CH-1:0] sw_rise,
    output logic [NUM_CH-1:0] sw_fall
`endif
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_raw  (sw_raw[ch]),
            .sw_db   (sw_db[ch]),
            .busy    (busy[ch])
`ifdef DEBOUNCE_EDGE_EN
            ,
            .sw_rise (sw_rise[ch]),
            .sw_fall (sw_fall[ch])
`endif
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (NUM_CH=2, DB_CYCLES=8, SYNC_STAGES=2).
// The reference model keeps a history of sampled raw levels: a channel's
// debounced level flips at the first edge where the last DB_CYCLES+1
// synchronised samples all differ from it.
module tb_switch_debouncer;
    import debounce_pkg::*;

    localparam int NCH  = 2;
    localparam int DB   = DB_CYCLES_SIM;
    localparam int SYNC = 2;
    localparam int HLEN = SYNC + DB + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] sw_raw = 2'b11;
    logic [NCH-1:0] sw_db, busy;
`ifdef DEBOUNCE_EDGE_EN
    logic [NCH-1:0] sw_rise, sw_fall;
`endif

    switch_debouncer #(
        .NUM_CH      (NCH),
        .DB_CYCLES   (DB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .sw_db   (sw_db),
        .busy    (busy)
`ifdef DEBOUNCE_EDGE_EN
        ,
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] db;
        logic [NCH-1:0] busy;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [NCH-1:0] act,
                         input logic [NCH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: hist[j] is the raw level sampled j edges ago.
    logic [NCH-1:0] hist[$];
    logic [NCH-1:0] m_db = '0;
    logic [NCH-1:0] m_prev = '0;

    always @(posedge clk) begin
        exp_t           e;
        logic [NCH-1:0] new_db;
        logic [NCH-1:0] m_busy;
        logic           flip;
        if (!rst_n) begin
            hist.delete();
            for (int j = 0; j < HLEN; j++) hist.push_back('0);
            m_db   = '0;
            m_prev = '0;
            m_busy = '0;
        end else begin
            hist.push_front(sw_raw);
            void'(hist.pop_back());
            new_db = m_db;
            for (int ch = 0; ch < NCH; ch++) begin
                flip = 1'b1;
                for (int j = SYNC; j <= SYNC + DB; j++)
                    if (hist[j][ch] == m_db[ch]) flip = 1'b0;
                m_busy[ch] = (hist[SYNC][ch] != m_db[ch]) && !flip;
                if (flip) new_db[ch] = ~m_db[ch];
            end
            m_prev = m_db;
            m_db   = new_db;
        end
        e.db   = m_db;
        e.busy = m_busy;
        e.rise = m_db & ~m_prev;
        e.fall = ~m_db & m_prev;
        sb_q.push_back(e);
    end

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sw_db", sw_db, e.db);
            check("busy", busy, e.busy);
`ifdef DEBOUNCE_EDGE_EN
            check("sw_rise", sw_rise, e.rise);
            check("sw_fall", sw_fall, e.fall);
`endif
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Asynchronous reset assertion away from both clock edges; outputs
    // must clear before any clock edge occurs.
    task automatic pulse_reset(input int n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_sw_db", sw_db, '0);
        check("rst_busy", busy, '0);
`ifdef DEBOUNCE_EDGE_EN
        check("rst_sw_rise", sw_rise, '0);
        check("rst_sw_fall", sw_fall, '0);
`endif
        cycles(n);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        // 1. Reset with both switches high, then release.
        cycles(4);
        #2 rst_n = 1'b1;
        cycles(14);

        // 2. Clean step on channel 0 (and fall back).
        sw_raw = 2'b00;
        cycles(14);
        sw_raw[0] = 1'b1;
        cycles(14);

        // 3. Bounce on channel 1, then hold high.
        sw_raw[1] = 1'b1; cycles(3);
        sw_raw[1] = 1'b0; cycles(3);
        sw_raw[1] = 1'b1; cycles(3);
        sw_raw[1] = 1'b0; cycles(3);
        sw_raw[1] = 1'b1; cycles(14);

        // 4. Glitch shorter than the window on channel 0.
        sw_raw = 2'b00;
        cycles(14);
        sw_raw[0] = 1'b1; cycles(5);
        sw_raw[0] = 1'b0; cycles(14);

        // 5. Reset mid-count, raw held high through release.
        sw_raw = 2'b11;
        cycles(2 + 4);
        pulse_reset(3);
        cycles(14);

        // 6. Simultaneous steps, then bounce channel 0 with channel 1 steady.
        sw_raw = 2'b00;
        cycles(14);
        sw_raw = 2'b11;
        cycles(14);
        for (int k = 0; k < 6; k++) begin
            sw_raw[0] = ~sw_raw[0];
            cycles(2 + k);
        end
        sw_raw[0] = 1'b1;
        cycles(14);

        // Randomised levels and hold times, including occasional resets.
        for (int k = 0; k < 120; k++) begin
            sw_raw = NCH'($urandom_range(0, 3));
            cycles($urandom_range(1, 14));
            if ($urandom_range(0, 29) == 0) pulse_reset($urandom_range(1, 3));
        end

        cycles(16);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
